// File: rtl/surf_cmd_pkg.sv
// Shared definitions for the TURF->SURF command link.
// The transmitter side imports the same frame constants.
package surf_cmd_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA6;
  localparam int         FRAME_LEN   = 7;

  typedef enum logic [2:0] {
    P_HUNT,
    P_BUF,
    P_EV3,
    P_EV2,
    P_EV1,
    P_EV0,
    P_SUM
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Only the two low bits of the buffer byte carry a buffer number.
  function automatic logic buf_byte_ok(input logic [7:0] b);
    return b[7:2] == 6'd0;
  endfunction

endpackage

// File: rtl/surf_uart_rx.sv
// 8N1 byte receiver for a 16x-style oversampled line: synchroniser,
// start-bit glitch rejection, centre sampling and stop-bit check.
module surf_uart_rx
  import surf_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       line_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       frame_err_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             line;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             bit_tick, stb_d, ferr_d;

  // Presetting to 1 makes the line look idle straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_i};
  end

  assign line = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!line) state_d = RX_START;
      RX_START: if (cnt_q == HALF_END) state_d = line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_q == BIT_END && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == BIT_END) state_d = line ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (line) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    bit_tick = (state_q == RX_DATA || state_q == RX_STOP) && (cnt_q == BIT_END);
    stb_d    = (state_q == RX_STOP) && bit_tick && line;
    ferr_d   = (state_q == RX_STOP) && bit_tick && !line;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_stb_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      byte_stb_o  <= stb_d;
      frame_err_o <= ferr_d;
      if (state_q != state_d || bit_tick || state_q == RX_IDLE || state_q == RX_BREAK)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == RX_START) begin
        bit_q <= '0;
      end else if (state_q == RX_DATA && bit_tick) begin
        shift_q <= {line, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/surf_command_receiver.sv
// SURF endpoint of the TURF command link: parses header/buffer/ID/checksum
// frames and presents accepted event IDs with a one-cycle valid strobe.
module surf_command_receiver
  import surf_cmd_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEADER_BYTE  = surf_cmd_pkg::HEADER_BYTE,
  parameter int         TIMEOUT_CLKS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_i,
  output logic [31:0] event_id_o,
  output logic [1:0]  buffer_o,
  output logic        valid_o,
  output logic        chk_err_o,
  output logic        fmt_err_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam int               TMO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT_CLKS);

  logic [7:0]       rx_byte;
  logic             rx_stb, rx_ferr;
  parser_state_t    state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  logic             timeout, abort;
  logic [31:0]      id_q;
  logic [1:0]       buf_q;
  logic [7:0]       sum_q;
  logic             valid_d, chk_d, fmt_d;

  surf_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .line_i      (cmd_i),
    .byte_o      (rx_byte),
    .byte_stb_o  (rx_stb),
    .frame_err_o (rx_ferr)
  );

  assign timeout = (state_q != P_HUNT) && (tmo_q == TMO_END);
  assign abort   = (state_q != P_HUNT) && (rx_ferr || timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= P_HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = P_HUNT;
    end else if (rx_stb) begin
      case (state_q)
        P_HUNT:  if (rx_byte == HEADER_BYTE) state_d = P_BUF;
        P_BUF:   state_d = buf_byte_ok(rx_byte) ? P_EV3 : P_HUNT;
        P_EV3:   state_d = P_EV2;
        P_EV2:   state_d = P_EV1;
        P_EV1:   state_d = P_EV0;
        P_EV0:   state_d = P_SUM;
        default: state_d = P_HUNT;
      endcase
    end
  end

  // Error priority: framing, then format/timeout, then checksum.
  always_comb begin
    fmt_d   = !rx_ferr && (timeout || (rx_stb && state_q == P_BUF && !buf_byte_ok(rx_byte)));
    chk_d   = !rx_ferr && !timeout && rx_stb && (state_q == P_SUM) && (rx_byte != sum_q);
    valid_d = !rx_ferr && !timeout && rx_stb && (state_q == P_SUM) && (rx_byte == sum_q);
    busy_o  = (state_q != P_HUNT);
  end

  // Staging registers id_q/buf_q only reach the outputs on a good checksum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q       <= '0;
      id_q        <= '0;
      buf_q       <= '0;
      sum_q       <= '0;
      event_id_o  <= '0;
      buffer_o    <= '0;
      valid_o     <= 1'b0;
      chk_err_o   <= 1'b0;
      fmt_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= valid_d;
      chk_err_o   <= chk_d;
      fmt_err_o   <= fmt_d;
      frame_err_o <= rx_ferr;
      if (state_q == P_HUNT || rx_stb) tmo_q <= '0;
      else                             tmo_q <= tmo_q + TMO_W'(1);
      if (rx_stb) begin
        case (state_q)
          P_BUF: begin
            buf_q <= rx_byte[1:0];
            sum_q <= '0;
          end
          P_EV3, P_EV2, P_EV1, P_EV0: begin
            id_q  <= {id_q[23:0], rx_byte};
            sum_q <= sum_q + rx_byte;
          end
          default: ;
        endcase
      end
      if (valid_d) begin
        event_id_o <= id_q;
        buffer_o   <= buf_q;
      end
    end
  end

endmodule
